// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter
// Synchronous cascade of DIGITS modulo-MOD digits with up/down count,
// parallel load, count enable and a combinational terminal-count output.
// Every digit updates on the same clock edge. Carry and borrow are resolved
// combinationally across the whole chain, so no stage ripples into the next.
// Optional feature macro: SQUARE_OUT_EN adds the sq_out divided square wave,
// which toggles on every full wrap.
module bcd_cascade_counter #(
    parameter int DIGITS = 3,
    parameter int MOD    = 10,
    parameter int W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_val,
    output logic [DIGITS*W-1:0] q,
    output logic                tc
`ifdef SQUARE_OUT_EN
    ,
    output logic                sq_out
`endif
);

    // Largest legal digit value. MOD is at most 2^W, so this fits in W bits.
    localparam logic [W-1:0] MAX_DIGIT = W'(MOD - 1);
    // Modulus widened by one bit. MOD == 2^W needs W+1 bits to compare.
    localparam logic [W:0]   MOD_EXT   = (W + 1)'(MOD);

    logic [DIGITS*W-1:0] q_reg;
    logic [DIGITS*W-1:0] count_next;
    logic [DIGITS*W-1:0] load_next;

    // carry_up[i]: all digits below i are at MAX_DIGIT.
    // carry_dn[i]: all digits below i are 0.
    // Index DIGITS covers the whole counter, so it marks a full wrap.
    logic [DIGITS:0] carry_up;
    logic [DIGITS:0] carry_dn;

    assign carry_up[0] = 1'b1;
    assign carry_dn[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [W-1:0] digit;
        logic [W-1:0] ld;
        logic         is_max;
        logic         is_zero;
        logic         step;

        assign digit   = q_reg[gi*W +: W];
        assign ld      = load_val[gi*W +: W];
        assign is_max  = (digit == MAX_DIGIT);
        assign is_zero = (digit == '0);

        assign carry_up[gi+1] = carry_up[gi] & is_max;
        assign carry_dn[gi+1] = carry_dn[gi] & is_zero;

        // A digit steps when every lower digit is at the wrap point for the
        // current direction. Digit 0 always sees a true carry-in.
        assign step = up ? carry_up[gi] : carry_dn[gi];

        assign count_next[gi*W +: W] =
            !step   ? digit :
            up      ? (is_max  ? '0        : digit + W'(1)) :
                      (is_zero ? MAX_DIGIT : digit - W'(1));

        // A loaded digit outside 0..MOD-1 is stored as 0, so the counter
        // never holds an invalid digit.
        assign load_next[gi*W +: W] = ({1'b0, ld} >= MOD_EXT) ? '0 : ld;
    end

    // Count register. Priority is reset, then load, then count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_next;
        end else if (en) begin
            q_reg <= count_next;
        end
    end

    assign q  = q_reg;
    assign tc = en & (up ? carry_up[DIGITS] : carry_dn[DIGITS]);

`ifdef SQUARE_OUT_EN
    logic sq_reg;

    // Toggle on each full wrap. A load on the same edge suppresses the toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_reg <= 1'b0;
        end else if (tc && !load) begin
            sq_reg <= ~sq_reg;
        end
    end

    assign sq_out = sq_reg;
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Testbench for bcd_cascade_counter. It covers DIGITS=3, MOD=10 and a
// DIGITS=1, MOD=2 instance that should behave like a T flip-flop.
// When SQUARE_OUT_EN is defined, the bench also checks the sq_out edges.
module tb_bcd_cascade_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;
    logic [11:0] q;
    logic        tc;
    logic [0:0]  t_load_val = '0;
    logic [0:0]  t_q;
    logic        t_tc;
`ifdef SQUARE_OUT_EN
    logic        sq_out;
    logic        t_sq_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_cascade_counter #(.DIGITS(3), .MOD(10), .W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q), .tc(tc)
`ifdef SQUARE_OUT_EN
        , .sq_out(sq_out)
`endif
    );

    bcd_cascade_counter #(.DIGITS(1), .MOD(2), .W(1)) dut_t (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(t_load_val), .q(t_q), .tc(t_tc)
`ifdef SQUARE_OUT_EN
        , .sq_out(t_sq_out)
`endif
    );

    typedef struct {
        logic        rst;
        logic        load;
        logic        en;
        logic        up;
        logic [11:0] lv;
        logic [11:0] exp_q;
        logic        exp_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the
    // next rising edge.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic u, input logic [11:0] lv);
        @(negedge clk);
        rst = r; load = l; en = e; up = u; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic e,
                                input logic u, input logic [11:0] lv,
                                input logic [11:0] eq, input logic et);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.up = u; v.lv = lv;
        v.exp_q = eq; v.exp_tc = et;
        return v;
    endfunction

    initial begin
        // Each row gives the inputs held for one edge, then the expected q
        // after that edge and the expected tc while those inputs are held.
        vecs.push_back(mk(1,0,0,0,12'h000, 12'h000, 0)); // reset, en=0
        vecs.push_back(mk(1,0,1,0,12'h000, 12'h000, 1)); // after reset, tc = en&~up
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h999, 0)); // borrow wrap
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h998, 0));
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h997, 0));
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h996, 0));
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h995, 0));
        vecs.push_back(mk(0,1,0,0,12'h5A3, 12'h503, 0)); // invalid digit forced to 0
        vecs.push_back(mk(0,1,1,1,12'h123, 12'h123, 0)); // load beats en
        vecs.push_back(mk(0,1,0,1,12'hFFF, 12'h000, 0)); // all digits invalid
        vecs.push_back(mk(0,1,0,1,12'h099, 12'h099, 0));
        vecs.push_back(mk(0,0,1,1,12'h000, 12'h100, 0)); // carry across two digits
        vecs.push_back(mk(0,1,0,0,12'h099, 12'h099, 0));
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h098, 0));
        vecs.push_back(mk(0,1,0,0,12'h500, 12'h500, 0));
        vecs.push_back(mk(0,0,1,1,12'h000, 12'h501, 0)); // direction toggles
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h500, 0));
        vecs.push_back(mk(0,0,1,1,12'h000, 12'h501, 0));
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h500, 0));
        vecs.push_back(mk(0,1,1,1,12'h999, 12'h999, 1)); // tc on all-9 while up
        vecs.push_back(mk(0,0,1,1,12'h000, 12'h000, 0)); // full up wrap
        vecs.push_back(mk(0,1,1,0,12'h000, 12'h000, 1)); // tc on all-0 while down
        vecs.push_back(mk(0,0,1,0,12'h000, 12'h999, 0));
        vecs.push_back(mk(0,1,0,0,12'h437, 12'h437, 0));
        vecs.push_back(mk(0,0,1,1,12'h000, 12'h438, 0));
        vecs.push_back(mk(1,1,1,1,12'h437, 12'h000, 0)); // reset beats load and en
        vecs.push_back(mk(0,1,0,1,12'h437, 12'h437, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
            check($sformatf("vec%0d q", i), {20'h0, q}, {20'h0, vecs[i].exp_q});
            check($sformatf("vec%0d tc", i), {31'h0, tc}, {31'h0, vecs[i].exp_tc});
        end

        // Hold test: with en=0, q keeps 437 for 10 edges.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 12'h000);
        check("hold10 q", {20'h0, q}, 32'h437);

        // Count 999 edges up from reset, then take one more edge to wrap.
        step(1, 0, 0, 1, 12'h000);
`ifdef SQUARE_OUT_EN
        check("sq reset", {31'h0, sq_out}, 32'h0);
`endif
        for (int i = 0; i < 999; i++) step(0, 0, 1, 1, 12'h000);
        check("up999 q", {20'h0, q}, 32'h999);
        check("up999 tc", {31'h0, tc}, 32'h1);
`ifdef SQUARE_OUT_EN
        check("sq edge999", {31'h0, sq_out}, 32'h0);
`endif
        step(0, 0, 1, 1, 12'h000);
        check("up1000 q", {20'h0, q}, 32'h000);
        check("up1000 tc", {31'h0, tc}, 32'h0);
`ifdef SQUARE_OUT_EN
        check("sq edge1000", {31'h0, sq_out}, 32'h1);
        for (int i = 0; i < 999; i++) step(0, 0, 1, 1, 12'h000);
        check("sq edge1999", {31'h0, sq_out}, 32'h1);
        step(0, 0, 1, 1, 12'h000);
        check("sq edge2000", {31'h0, sq_out}, 32'h0);
        // A load while tc is high must not toggle sq_out.
        step(0, 1, 1, 1, 12'h999);
        step(0, 1, 1, 1, 12'h000);
        check("sq load no toggle", {31'h0, sq_out}, 32'h0);
`endif

        // The MOD=2, DIGITS=1 instance toggles on every enabled edge.
        step(1, 0, 0, 1, 12'h000);
        check("tff reset", {31'h0, t_q}, 32'h0);
        step(0, 0, 1, 1, 12'h000);
        check("tff edge1", {31'h0, t_q}, 32'h1);
        check("tff tc", {31'h0, t_tc}, 32'h1);
        step(0, 0, 1, 1, 12'h000);
        check("tff edge2", {31'h0, t_q}, 32'h0);
        step(0, 0, 1, 0, 12'h000);
        check("tff edge3 down", {31'h0, t_q}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
